mem_port_arbiter: RTL and testbench

- Shares the single external memory port between instruction fetch (IF) and the memory stage (MEM, loads/stores).
- Arbitrates with MEM priority, bounded by an anti-starvation limit for IF.
- Holds bus signals stable through the req/ack handshake and routes the returned data and a one-cycle ack back to the owner.
- Drops fetch responses that were flushed in flight, and bounds every transaction with a timeout.

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and the memory stage.
// MEM has priority, bounded by a streak limit; every transaction is bounded by a timeout.
module mem_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    input  logic            i_if_flush,
    output logic            o_if_ack,
    output logic [XLEN-1:0] o_if_data,
    input  logic            i_d_req,
    input  logic [XLEN-1:0] i_d_addr,
    input  logic [XLEN-1:0] i_d_wdata,
    input  logic [2:0]      i_d_funct3,
    input  logic            i_d_we,
    output logic            o_d_ack,
    output logic [XLEN-1:0] o_d_rdata,
    output logic            o_bus_req,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [XLEN-1:0] o_bus_wdata,
    output logic [2:0]      o_bus_funct3,
    output logic            o_bus_we,
    input  logic            i_bus_ack,
    input  logic [XLEN-1:0] i_bus_rdata,
    output logic            o_timeout
);

    localparam int unsigned StreakW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam int unsigned TimerW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);
    localparam logic [TimerW-1:0]  TimerLast = TimerW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e              state_q, state_d;
    logic                owner_d_q, owner_d_d;   // 1 = MEM owns the bus, 0 = IF
    logic                drop_q, drop_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                bus_req_q, bus_req_d;
    logic [XLEN-1:0]     bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]     bus_wdata_q, bus_wdata_d;
    logic [2:0]          bus_funct3_q, bus_funct3_d;
    logic                bus_we_q, bus_we_d;
    logic                if_ack_q, if_ack_d;
    logic [XLEN-1:0]     if_data_q, if_data_d;
    logic                d_ack_q, d_ack_d;
    logic [XLEN-1:0]     d_rdata_q, d_rdata_d;
    logic                timeout_q, timeout_d;
    logic                if_valid, d_grant, if_grant;
    logic [XLEN-1:0]     resp_data;

    assign if_valid = i_if_req && !i_if_flush;

    always_comb begin
        state_d      = state_q;
        owner_d_d    = owner_d_q;
        drop_d       = drop_q;
        streak_d     = streak_q;
        timer_d      = timer_q;
        bus_req_d    = bus_req_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_funct3_d = bus_funct3_q;
        bus_we_d     = bus_we_q;
        if_ack_d     = 1'b0;
        if_data_d    = if_data_q;
        d_ack_d      = 1'b0;
        d_rdata_d    = d_rdata_q;
        timeout_d    = 1'b0;
        d_grant      = 1'b0;
        if_grant     = 1'b0;
        resp_data    = '0;

        unique case (state_q)
            StIdle: begin
                drop_d = 1'b0;
                if (i_d_req && !(if_valid && streak_q == StreakMax)) begin
                    d_grant      = 1'b1;
                    owner_d_d    = 1'b1;
                    bus_addr_d   = i_d_addr;
                    bus_wdata_d  = i_d_wdata;
                    bus_funct3_d = i_d_funct3;
                    bus_we_d     = i_d_we;
                end else if (if_valid) begin
                    if_grant     = 1'b1;
                    owner_d_d    = 1'b0;
                    bus_addr_d   = i_if_addr;
                    bus_funct3_d = 3'b010;
                    bus_we_d     = 1'b0;
                end
                if (d_grant || if_grant) begin
                    bus_req_d = 1'b1;
                    timer_d   = '0;
                    state_d   = StBus;
                end
            end
            StBus: begin
                timer_d = timer_q + 1'b1;
                // A flush on the completing edge still suppresses the fetch ack.
                drop_d  = drop_q || (!owner_d_q && i_if_flush);
                if (i_bus_ack || timer_q == TimerLast) begin
                    resp_data = i_bus_ack ? i_bus_rdata : '0;
                    bus_req_d = 1'b0;
                    timeout_d = !i_bus_ack;
                    state_d   = StResp;
                    if (owner_d_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = resp_data;
                    end else if (!drop_d) begin
                        if_ack_d  = 1'b1;
                        if_data_d = resp_data;
                    end
                end
            end
            StResp: begin
                drop_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (!if_valid || if_grant) begin
            streak_d = '0;
        end else if (d_grant && streak_q != StreakMax) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            owner_d_q    <= 1'b0;
            drop_q       <= 1'b0;
            streak_q     <= '0;
            timer_q      <= '0;
            bus_req_q    <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_funct3_q <= '0;
            bus_we_q     <= 1'b0;
            if_ack_q     <= 1'b0;
            if_data_q    <= '0;
            d_ack_q      <= 1'b0;
            d_rdata_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_d_q    <= owner_d_d;
            drop_q       <= drop_d;
            streak_q     <= streak_d;
            timer_q      <= timer_d;
            bus_req_q    <= bus_req_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_funct3_q <= bus_funct3_d;
            bus_we_q     <= bus_we_d;
            if_ack_q     <= if_ack_d;
            if_data_q    <= if_data_d;
            d_ack_q      <= d_ack_d;
            d_rdata_q    <= d_rdata_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_if_ack     = if_ack_q;
    assign o_if_data    = if_data_q;
    assign o_d_ack      = d_ack_q;
    assign o_d_rdata    = d_rdata_q;
    assign o_bus_req    = bus_req_q;
    assign o_bus_addr   = bus_addr_q;
    assign o_bus_wdata  = bus_wdata_q;
    assign o_bus_funct3 = bus_funct3_q;
    assign o_bus_we     = bus_we_q;
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: priority, streak limit, flush, timeout, async reset.
module tb_mem_port_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = '0;
    logic        i_if_flush = 1'b0;
    logic        o_if_ack;
    logic [31:0] o_if_data;
    logic        i_d_req = 1'b0;
    logic [31:0] i_d_addr = '0;
    logic [31:0] i_d_wdata = '0;
    logic [2:0]  i_d_funct3 = '0;
    logic        i_d_we = 1'b0;
    logic        o_d_ack;
    logic [31:0] o_d_rdata;
    logic        o_bus_req;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [2:0]  o_bus_funct3;
    logic        o_bus_we;
    logic        i_bus_ack = 1'b0;
    logic [31:0] i_bus_rdata = '0;
    logic        o_timeout;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_if_data;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter #(
        .XLEN        (32),
        .MAX_D_STREAK(4),
        .TIMEOUT     (8)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .i_if_flush  (i_if_flush),
        .o_if_ack    (o_if_ack),
        .o_if_data   (o_if_data),
        .i_d_req     (i_d_req),
        .i_d_addr    (i_d_addr),
        .i_d_wdata   (i_d_wdata),
        .i_d_funct3  (i_d_funct3),
        .i_d_we      (i_d_we),
        .o_d_ack     (o_d_ack),
        .o_d_rdata   (o_d_rdata),
        .o_bus_req   (o_bus_req),
        .o_bus_addr  (o_bus_addr),
        .o_bus_wdata (o_bus_wdata),
        .o_bus_funct3(o_bus_funct3),
        .o_bus_we    (o_bus_we),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata),
        .o_timeout   (o_timeout)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_bus_req(input string tag);
        int cnt = 0;
        while (!o_bus_req && cnt < 20) begin
            tick();
            cnt++;
        end
        check_eq({tag, "_req_seen"}, 32'(o_bus_req), 32'd1);
    endtask

    // Grant, one-cycle bus ack, owner ack check, then step through RESP.
    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic is_if,
                         input logic [31:0] data);
        wait_bus_req(tag);
        check_eq({tag, "_addr"}, o_bus_addr, exp_addr);
        i_bus_ack   = 1'b1;
        i_bus_rdata = data;
        tick();
        i_bus_ack = 1'b0;
        if (is_if) begin
            check_eq({tag, "_if_ack"}, 32'(o_if_ack), 32'd1);
            check_eq({tag, "_if_data"}, o_if_data, data);
        end else begin
            check_eq({tag, "_d_ack"}, 32'(o_d_ack), 32'd1);
            check_eq({tag, "_d_rdata"}, o_d_rdata, data);
        end
        tick();
    endtask

    initial begin
        #12;
        check_eq("rst_bus_req", 32'(o_bus_req), 32'd0);
        check_eq("rst_if_ack", 32'(o_if_ack), 32'd0);
        check_eq("rst_d_ack", 32'(o_d_ack), 32'd0);
        check_eq("rst_timeout", 32'(o_timeout), 32'd0);
        check_eq("rst_if_data", o_if_data, 32'd0);
        check_eq("rst_d_rdata", o_d_rdata, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // IF-only fetch
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0100;
        tick();
        check_eq("t1_bus_req", 32'(o_bus_req), 32'd1);
        check_eq("t1_funct3", 32'(o_bus_funct3), 32'd2);
        check_eq("t1_we", 32'(o_bus_we), 32'd0);
        check_eq("t1_addr", o_bus_addr, 32'h0000_0100);
        tick();
        check_eq("t1_req_held", 32'(o_bus_req), 32'd1);
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'h0010_0093;
        tick();
        i_bus_ack = 1'b0;
        i_if_req  = 1'b0;
        check_eq("t1_if_ack", 32'(o_if_ack), 32'd1);
        check_eq("t1_if_data", o_if_data, 32'h0010_0093);
        check_eq("t1_d_ack", 32'(o_d_ack), 32'd0);
        check_eq("t1_req_drop", 32'(o_bus_req), 32'd0);
        tick();
        check_eq("t1_if_ack_pulse", 32'(o_if_ack), 32'd0);
        tick();

        // Simultaneous requests: store first, then fetch after RESP
        i_if_req   = 1'b1;
        i_if_addr  = 32'h0000_0104;
        i_d_req    = 1'b1;
        i_d_addr   = 32'h0000_2004;
        i_d_wdata  = 32'hDEAD_BEEF;
        i_d_funct3 = 3'b010;
        i_d_we     = 1'b1;
        tick();
        check_eq("t2_st_addr", o_bus_addr, 32'h0000_2004);
        check_eq("t2_st_we", 32'(o_bus_we), 32'd1);
        check_eq("t2_st_wdata", o_bus_wdata, 32'hDEAD_BEEF);
        i_bus_ack = 1'b1;
        tick();
        i_bus_ack = 1'b0;
        i_d_req   = 1'b0;
        check_eq("t2_d_ack", 32'(o_d_ack), 32'd1);
        check_eq("t2_if_ack", 32'(o_if_ack), 32'd0);
        tick();
        check_eq("t2_resp_no_grant", 32'(o_bus_req), 32'd0);
        tick();
        check_eq("t2_if_req", 32'(o_bus_req), 32'd1);
        check_eq("t2_if_addr", o_bus_addr, 32'h0000_0104);
        check_eq("t2_if_we", 32'(o_bus_we), 32'd0);
        check_eq("t2_if_funct3", 32'(o_bus_funct3), 32'd2);
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'h0041_0113;
        tick();
        i_bus_ack = 1'b0;
        i_if_req  = 1'b0;
        check_eq("t2_if_ack2", 32'(o_if_ack), 32'd1);
        check_eq("t2_if_data", o_if_data, 32'h0041_0113);
        tick();
        tick();

        // Streak limit: 4 MEM grants, 1 IF grant, MEM again
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0200;
        i_d_req   = 1'b1;
        i_d_addr  = 32'h0000_3000;
        i_d_we    = 1'b0;
        for (int g = 0; g < 4; g++) begin
            serve("t3_mem", 32'h0000_3000, 1'b0, 32'h1000_0000 + 32'(g));
        end
        serve("t3_if", 32'h0000_0200, 1'b1, 32'h0020_0213);
        exp_if_data = 32'h0020_0213;
        serve("t3_mem_again", 32'h0000_3000, 1'b0, 32'h2000_0000);
        i_if_req = 1'b0;
        i_d_req  = 1'b0;
        tick();
        tick();

        // Flush during IF BUS phase
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0300;
        tick();
        check_eq("t4_req", 32'(o_bus_req), 32'd1);
        i_if_flush = 1'b1;
        i_if_req   = 1'b0;
        tick();
        i_if_flush  = 1'b0;
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'hBAD0_BAD0;
        tick();
        i_bus_ack = 1'b0;
        check_eq("t4_ack_consumed", 32'(o_bus_req), 32'd0);
        check_eq("t4_no_if_ack", 32'(o_if_ack), 32'd0);
        check_eq("t4_if_data_kept", o_if_data, exp_if_data);
        tick();
        i_d_req  = 1'b1;
        i_d_addr = 32'h0000_0400;
        serve("t4_mem", 32'h0000_0400, 1'b0, 32'h0000_55AA);
        i_d_req = 1'b0;
        tick();

        // Timeout: memory never acks
        begin
            int cnt = 0;
            i_d_req  = 1'b1;
            i_d_addr = 32'h0000_0500;
            tick();
            while (o_bus_req && cnt < 20) begin
                cnt++;
                tick();
            end
            i_d_req = 1'b0;
            check_eq("t5_bus_cycles", 32'(cnt), 32'd8);
            check_eq("t5_timeout", 32'(o_timeout), 32'd1);
            check_eq("t5_d_ack", 32'(o_d_ack), 32'd1);
            check_eq("t5_d_rdata", o_d_rdata, 32'd0);
        end
        tick();
        check_eq("t5_timeout_pulse", 32'(o_timeout), 32'd0);
        tick();
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'h0000_1234;
        tick();
        i_bus_ack = 1'b0;
        check_eq("t5_stray_d_ack", 32'(o_d_ack), 32'd0);
        check_eq("t5_stray_if_ack", 32'(o_if_ack), 32'd0);
        tick();
        check_eq("t5_stray_req", 32'(o_bus_req), 32'd0);
        check_eq("t5_stray_rdata", o_d_rdata, 32'd0);

        // Async reset mid-BUS with streak at its limit
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0600;
        i_d_req   = 1'b1;
        i_d_addr  = 32'h0000_0700;
        i_d_wdata = 32'hCAFE_F00D;
        i_d_we    = 1'b1;
        for (int g = 0; g < 3; g++) begin
            serve("t6_pre", 32'h0000_0700, 1'b0, 32'h3000_0000 + 32'(g));
        end
        wait_bus_req("t6_fourth");
        check_eq("t6_fourth_addr", o_bus_addr, 32'h0000_0700);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("t6_rst_bus_req", 32'(o_bus_req), 32'd0);
        check_eq("t6_rst_d_ack", 32'(o_d_ack), 32'd0);
        check_eq("t6_rst_if_ack", 32'(o_if_ack), 32'd0);
        #1;
        i_rst_n = 1'b1;
        serve("t6_post", 32'h0000_0700, 1'b0, 32'h4000_0000);
        i_if_req = 1'b0;
        i_d_req  = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
